// File: rtl/masked_key_transmitter.sv
// Key-slot store plus a three-state sender that streams payload ^ key ^ msg_ctr
// as LANE_W beats, least-significant lane first, over a valid/ready link.
module masked_key_transmitter #(
  parameter int DATA_W    = 128,
  parameter int LANE_W    = 32,
  parameter int NUM_SLOTS = 4,
  parameter int CTR_W     = 16,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_wr_en,
  input  logic [SLOT_W-1:0] key_wr_slot,
  input  logic [DATA_W-1:0] key_wr_data,
  output logic              key_wr_err,
  input  logic              zeroize,
  input  logic              tx_req,
  input  logic [SLOT_W-1:0] tx_slot,
  input  logic [DATA_W-1:0] tx_payload,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_err,
  output logic [LANE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CTR_W-1:0]  msg_ctr
);
  localparam int BEATS  = DATA_W / LANE_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam int NSLOT_P2 = 2 ** SLOT_W;
  // Slot addresses beyond NUM_SLOTS can never become valid.
  localparam logic [NSLOT_P2-1:0] SLOT_MASK = NSLOT_P2'({NUM_SLOTS{1'b1}});

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]   keys [NSLOT_P2];
  logic [NSLOT_P2-1:0] key_valid;
  logic [DATA_W-1:0]   lat_key, lat_payload;
  logic [SLOT_W-1:0]   lat_slot;
  logic [BEAT_W-1:0]   beat_idx;
  logic                slot_ok, accept, beat_fire, last_fire, wr_blocked;

  always_comb begin
    slot_ok    = key_valid[tx_slot];
    accept     = (state == IDLE) && tx_req && slot_ok;
    beat_fire  = (state == SEND) && out_ready;
    last_fire  = beat_fire && (beat_idx == LAST_BEAT);
    wr_blocked = tx_busy && (key_wr_slot == lat_slot);
  end

  assign tx_busy   = (state != IDLE);
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (beat_idx == LAST_BEAT);
  // Gated so nothing derived from the latched key leaves the block outside SEND.
  assign out_data  = out_valid ? (lat_payload[beat_idx*LANE_W +: LANE_W] ^
                                  lat_key[beat_idx*LANE_W +: LANE_W] ^
                                  LANE_W'(msg_ctr)) : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (last_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (zeroize) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    tx_done    <= 1'b0;
    tx_err     <= 1'b0;
    key_wr_err <= 1'b0;
    if (reset) begin
      for (int s = 0; s < NSLOT_P2; s++) keys[s] <= '0;
      key_valid   <= '0;
      lat_key     <= '0;
      lat_payload <= '0;
      lat_slot    <= '0;
      beat_idx    <= '0;
      msg_ctr     <= '0;
    end else if (zeroize) begin
      for (int s = 0; s < NSLOT_P2; s++) keys[s] <= '0;
      key_valid   <= '0;
      lat_key     <= '0;
      lat_payload <= '0;
      beat_idx    <= '0;
    end else begin
      // Same-cycle tx_req latches the pre-write key since both update at this edge.
      if (key_wr_en && SLOT_MASK[key_wr_slot]) begin
        if (wr_blocked) key_wr_err <= 1'b1;
        else begin
          keys[key_wr_slot]      <= key_wr_data;
          key_valid[key_wr_slot] <= 1'b1;
        end
      end
      if (accept) begin
        lat_key     <= keys[tx_slot];
        lat_payload <= tx_payload;
        lat_slot    <= tx_slot;
        beat_idx    <= '0;
      end
      if ((state == IDLE) && tx_req && !slot_ok) tx_err <= 1'b1;
      if (beat_fire) beat_idx <= beat_idx + BEAT_W'(1);
      if (last_fire) begin
        beat_idx <= '0;
        tx_done  <= 1'b1;
        msg_ctr  <= msg_ctr + CTR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_masked_key_transmitter.sv
// Directed bench: a queue model predicts every beat from payload ^ key ^ counter;
// a negedge process checks beats, tx_done and msg_ctr each cycle.
module tb_masked_key_transmitter;
  localparam int BEATS = 4;

  logic         clk = 1'b0, reset = 1'b1;
  logic         key_wr_en = 1'b0, zeroize = 1'b0, tx_req = 1'b0, out_ready = 1'b1;
  logic [1:0]   key_wr_slot = '0, tx_slot = '0;
  logic [127:0] key_wr_data = '0, tx_payload = '0;
  logic         key_wr_err, tx_busy, tx_done, tx_err, out_valid, out_last;
  logic [31:0]  out_data;
  logic [15:0]  msg_ctr;

  always #5 clk = ~clk;

  masked_key_transmitter dut (
    .clk(clk), .reset(reset),
    .key_wr_en(key_wr_en), .key_wr_slot(key_wr_slot), .key_wr_data(key_wr_data),
    .key_wr_err(key_wr_err), .zeroize(zeroize),
    .tx_req(tx_req), .tx_slot(tx_slot), .tx_payload(tx_payload),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .msg_ctr(msg_ctr)
  );

  typedef struct { logic [31:0] data; logic last; } beat_t;
  beat_t        exp_q[$];
  logic [127:0] m_key [4];
  logic [3:0]   m_vld = '0;
  logic [15:0]  m_ctr = '0;
  logic [1:0]   m_slot = '0;
  logic exp_err = 0, exp_kerr = 0, exp_done = 0;
  logic flush = 0, do_rst = 0, chk_on = 0, issued_now = 0;
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    chk("tx_done", {63'd0, tx_done}, {63'd0, exp_done});
    chk("msg_ctr", {48'd0, msg_ctr}, {48'd0, m_ctr});
    exp_done = 1'b0;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected out_valid", {63'd0, out_valid}, 64'd0);
      else begin
        chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0].data});
        chk("out_last", {63'd0, out_last}, {63'd0, exp_q[0].last});
        if (out_ready) begin
          if (exp_q[0].last) begin exp_done = 1'b1; m_ctr = m_ctr + 16'd1; end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    tx_req = 0; key_wr_en = 0; zeroize = 0; reset = 0; issued_now = 0;
    if (flush) begin exp_q.delete(); flush = 0; end
    if (do_rst) begin m_ctr = '0; do_rst = 0; end
    chk("tx_err", {63'd0, tx_err}, {63'd0, exp_err});
    chk("key_wr_err", {63'd0, key_wr_err}, {63'd0, exp_kerr});
    exp_err = 0; exp_kerr = 0;
  endtask

  task automatic issue(input logic [1:0] slot, input logic [127:0] pl);
    tx_req = 1; tx_slot = slot; tx_payload = pl;
    if (exp_q.size() != 0) return;
    issued_now = 1;
    if (m_vld[slot]) begin
      m_slot = slot;
      for (int i = 0; i < BEATS; i++)
        exp_q.push_back('{data: pl[i*32 +: 32] ^ m_key[slot][i*32 +: 32] ^ {16'h0, m_ctr},
                          last: (i == BEATS-1)});
    end else exp_err = 1;
  endtask

  task automatic kw(input logic [1:0] slot, input logic [127:0] k);
    key_wr_en = 1; key_wr_slot = slot; key_wr_data = k;
    if (exp_q.size() != 0 && !issued_now && slot == m_slot) exp_kerr = 1;
    else begin m_key[slot] = k; m_vld[slot] = 1; end
  endtask

  task automatic wipe_model();
    m_vld = '0;
    for (int s = 0; s < 4; s++) m_key[s] = '0;
    flush = 1; exp_err = 0; exp_kerr = 0;
  endtask

  task automatic zz();
    zeroize = 1; wipe_model();
  endtask

  task automatic rst_pulse();
    reset = 1; wipe_model(); do_rst = 1;
  endtask

  task automatic drain(input int stall_beat, input int stall_n, input int abort_beat, input bit by_rst);
    int  stalls = 0;
    bit  aborted = 0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      int cur = BEATS - exp_q.size();
      out_ready = 1;
      if (cur == stall_beat && stalls < stall_n && out_valid) begin out_ready = 0; stalls++; end
      if (cur == abort_beat && out_valid) begin
        if (by_rst) rst_pulse(); else zz();
        aborted = 1;
      end
      step();
      if (aborted) chk("abort drops out_valid", {63'd0, out_valid}, 64'd0);
    end
    out_ready = 1;
    if (exp_q.size() != 0) begin
      chk("drain timeout beats left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    step();
    chk("tx_busy after transfer", {63'd0, tx_busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e2 [4];
    for (int s = 0; s < 4; s++) m_key[s] = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset outputs", {10'd0, out_data, out_valid, out_last, tx_busy, tx_done,
                          tx_err, key_wr_err, msg_ctr}, 64'd0);
    chk_on = 1;

    // basic transfer, first beat two cycles after request
    kw(0, 128'h00000004_00000003_00000002_00000001); step();
    issue(0, '0);
    for (int i = 0; i < BEATS; i++) chk("model basic beat", {32'd0, exp_q[i].data}, 64'(i + 1));
    step();
    chk("LOAD cycle out_valid", {63'd0, out_valid}, 64'd0);
    chk("LOAD cycle tx_busy", {63'd0, tx_busy}, 64'd1);
    step();
    chk("first out_valid at +2", {63'd0, out_valid}, 64'd1);
    drain(-1, 0, -1, 0);
    chk("msg_ctr after first", {48'd0, msg_ctr}, 64'd1);

    // same key and payload, counter now 1
    e2 = '{32'h0, 32'h3, 32'h2, 32'h5};
    issue(0, '0);
    for (int i = 0; i < BEATS; i++) chk("model second beat", {32'd0, exp_q[i].data}, {32'd0, e2[i]});
    step(); drain(-1, 0, -1, 0);

    // invalid slot
    issue(2, 128'h1234); step(); step(); step();
    chk("msg_ctr after reject", {48'd0, msg_ctr}, 64'd2);

    // backpressure on beat 1
    issue(0, 128'h01234567_89ABCDEF_FEDCBA98_76543210); step();
    drain(1, 3, -1, 0);

    // key write collisions: same-cycle request uses old key, busy write rejected
    kw(1, 128'h11111111_22222222_33333333_44444444); step();
    issue(1, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
    kw(1, 128'hCAFEBABE_DEADBEEF_00C0FFEE_BAADF00D); step();
    kw(1, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF); step();
    drain(-1, 0, -1, 0);
    issue(1, '0); step(); drain(-1, 0, -1, 0);

    // zeroize during beat 2
    issue(0, 128'h55); step(); drain(-1, 0, 2, 0);
    issue(0, 128'h55); step(); step();

    // key write and zeroize together
    kw(3, 128'h77); zz(); step();
    issue(3, '0); step(); step();

    // counter wrap
    kw(0, 128'h9); step();
    force dut.msg_ctr = 16'hFFFF; m_ctr = 16'hFFFF;
    step();
    release dut.msg_ctr;
    step();
    issue(0, 128'h3); step(); drain(-1, 0, -1, 0);
    chk("msg_ctr wrap", {48'd0, msg_ctr}, 64'd0);

    // reset aborts mid-transfer and clears keys
    kw(2, 128'h12345678); step();
    issue(2, '0); step(); drain(-1, 0, 1, 1);
    issue(2, '0); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
